present_dec_core: RTL



---
 rtl/present_dec_core.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/present_dec_core.sv
`default_nettype none
// ============================================================================
// Module   : present_dec_core
// Brief    : Iterative PRESENT-80 decryption core, one round per clock.
//            Optional macro PRESENT_DEC_KEYCACHE_EN keeps the last expanded
//            key (input key and K32) so a repeated key skips key expansion.
// Revision : 1.0 - initial release
// ============================================================================
module present_dec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    output logic        busy,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key,
    output logic [63:0] plaintext,
    output logic        done
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_KEYEXP = 2'd1;
    localparam logic [1:0] c_ST_WHITEN = 2'd2;
    localparam logic [1:0] c_ST_DEC    = 2'd3;
    localparam logic [4:0] c_RND_LAST  = 5'd31;
    localparam logic [4:0] c_RND_FIRST = 5'd1;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] f_sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Inverse round without key: undo the bit permutation, then the S-box layer.
    function automatic logic [63:0] f_inv_layer(input logic [63:0] s);
        logic [63:0] p;
        logic [63:0] o;
        for (int i = 0; i < 63; i++) begin
            p[i] = s[(16 * i) % 63];
        end
        p[63] = s[63];
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = f_sbox_inv(p[4*n +: 4]);
        end
        return o;
    endfunction

    logic [1:0]  r_st;
    logic [4:0]  r_rnd;
    logic [79:0] r_key;
    logic [63:0] r_state;
    logic [63:0] r_pt;
    logic        r_done;

    logic [1:0]  w_st_nxt;
    logic [4:0]  w_rnd_nxt;
    logic [79:0] w_key_nxt;
    logic [63:0] w_state_nxt;
    logic [63:0] w_pt_nxt;
    logic        w_done_nxt;

    logic [79:0] w_key_rot;
    logic [79:0] w_key_fwd;
    logic [79:0] w_key_unx;
    logic [79:0] w_key_prev;
    logic [63:0] w_dec_state;

    assign w_key_rot   = {r_key[18:0], r_key[79:19]};
    assign w_key_fwd   = {f_sbox(w_key_rot[79:76]), w_key_rot[75:20],
                          w_key_rot[19:15] ^ r_rnd, w_key_rot[14:0]};
    assign w_key_unx   = {f_sbox_inv(r_key[79:76]), r_key[75:20],
                          r_key[19:15] ^ r_rnd, r_key[14:0]};
    assign w_key_prev  = {w_key_unx[60:0], w_key_unx[79:61]};
    assign w_dec_state = f_inv_layer(r_state) ^ w_key_prev[79:16];

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [79:0] r_ck_key;
    logic [79:0] r_ck_k32;
    logic        r_ck_valid;
    logic [79:0] w_ck_key_nxt;
    logic [79:0] w_ck_k32_nxt;
    logic        w_ck_valid_nxt;
    logic        w_ck_hit;

    assign w_ck_hit = r_ck_valid && (key == r_ck_key);
`endif

    always_comb begin
        w_st_nxt    = r_st;
        w_rnd_nxt   = r_rnd;
        w_key_nxt   = r_key;
        w_state_nxt = r_state;
        w_pt_nxt    = r_pt;
        w_done_nxt  = 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
        w_ck_key_nxt   = r_ck_key;
        w_ck_k32_nxt   = r_ck_k32;
        w_ck_valid_nxt = r_ck_valid;
`endif
        case (r_st)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ciphertext;
                    w_key_nxt   = key;
                    w_rnd_nxt   = c_RND_FIRST;
                    w_st_nxt    = c_ST_KEYEXP;
`ifdef PRESENT_DEC_KEYCACHE_EN
                    if (w_ck_hit) begin
                        w_key_nxt = r_ck_k32;
                        w_st_nxt  = c_ST_WHITEN;
                    end else begin
                        // The entry only becomes valid once this key is fully expanded.
                        w_ck_key_nxt   = key;
                        w_ck_valid_nxt = 1'b0;
                    end
`endif
                end
            end
            c_ST_KEYEXP: begin
                w_key_nxt = w_key_fwd;
                if (r_rnd == c_RND_LAST) begin
                    w_st_nxt = c_ST_WHITEN;
`ifdef PRESENT_DEC_KEYCACHE_EN
                    w_ck_k32_nxt   = w_key_fwd;
                    w_ck_valid_nxt = 1'b1;
`endif
                end else begin
                    w_rnd_nxt = r_rnd + 5'd1;
                end
            end
            c_ST_WHITEN: begin
                w_state_nxt = r_state ^ r_key[79:16];
                w_rnd_nxt   = c_RND_LAST;
                w_st_nxt    = c_ST_DEC;
            end
            default: begin
                w_key_nxt   = w_key_prev;
                w_state_nxt = w_dec_state;
                if (r_rnd == c_RND_FIRST) begin
                    w_pt_nxt   = w_dec_state;
                    w_done_nxt = 1'b1;
                    w_rnd_nxt  = 5'd0;
                    w_st_nxt   = c_ST_IDLE;
                end else begin
                    w_rnd_nxt = r_rnd - 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st    <= c_ST_IDLE;
            r_rnd   <= 5'd0;
            r_key   <= 80'd0;
            r_state <= 64'd0;
            r_pt    <= 64'd0;
            r_done  <= 1'b0;
`ifdef PRESENT_DEC_KEYCACHE_EN
            r_ck_key   <= 80'd0;
            r_ck_k32   <= 80'd0;
            r_ck_valid <= 1'b0;
`endif
        end else begin
            r_st    <= w_st_nxt;
            r_rnd   <= w_rnd_nxt;
            r_key   <= w_key_nxt;
            r_state <= w_state_nxt;
            r_pt    <= w_pt_nxt;
            r_done  <= w_done_nxt;
`ifdef PRESENT_DEC_KEYCACHE_EN
            r_ck_key   <= w_ck_key_nxt;
            r_ck_k32   <= w_ck_k32_nxt;
            r_ck_valid <= w_ck_valid_nxt;
`endif
        end
    end

    assign ready     = (r_st == c_ST_IDLE);
    assign busy      = (r_st != c_ST_IDLE);
    assign plaintext = r_pt;
    assign done      = r_done;

endmodule
`default_nettype wire
